req_initiator: RTL and testbench
================================

Name: req_initiator

Overview:
- Requester side of the single-wire req/ack handshake; drives `req` toward the fixed-latency responder FSM and consumes its `ack`.
- Issues a programmed number of transactions per `start`, counts acks, flags missing acks by timeout.
- Sits between a control/CSR block (`start`, `num_txn`) and the responder.

Parameters:
- CNT_W, 8, width of `num_txn` and `ack_count`.
- TIMEOUT_CYCLES, 16, WAIT cycles without ack before error; must exceed RESP_LAT.
- RESP_LAT, 5, responder latency: clock edges from `req` sampled to `ack` high.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  begin a batch; sampled only in IDLE.
- num_txn  input  CNT_W  transactions in batch; latched on accepted start.
- ack  input  1  responder acknowledge, one-cycle pulse.
- req  output  1  request to responder.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse after the final ack of a batch.
- timeout_err  output  1  sticky error flag.
- ack_count  output  CNT_W  acks received in the current batch.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: req=0, busy=0, done=0, timeout_err=0, ack_count=0, remaining=0, timer=0, state=IDLE.
- Output timing: all outputs registered or decoded from the state register (Moore); no combinational path from ack to req.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - start=1 latches num_txn into remaining, clears ack_count and timeout_err.
  - If num_txn==0: done pulses next cycle, no req, stay IDLE.
  - Else go to ISSUE.
  - start while busy is ignored.
- ISSUE: req=1 for exactly this one cycle; timer cleared; next state WAIT.
- WAIT:
  - req=0; timer increments each cycle.
  - On ack=1: ack_count++ (wraps mod 2^CNT_W) and remaining--.
  - If remaining was 1, go to IDLE and pulse done the following cycle; else go to ISSUE.
- Timeout: timer reaches TIMEOUT_CYCLES with no ack -> IDLE, timeout_err=1 (held until next accepted start or rst), no done pulse.
- Stray ack: ack outside WAIT is ignored and not counted.
- Ack in final timer cycle: treated as ack, not timeout.
- Throughput with RESP_LAT=5: 6-cycle period (ISSUE + 5 WAIT, ack in the 5th WAIT cycle). req is low in the responder's ack cycle, so the responder returns to idle.
- Reset mid-operation: asynchronous return to reset values; req drops immediately; in-flight ack is lost.

Optional Feature:
- Macro: REQ_B2B_EN.
- Defined:
  - In WAIT, when timer == RESP_LAT-1 (the expected ack cycle) and remaining>1, req is asserted speculatively in that cycle.
  - If ack=1 in that cycle: responder restarts directly; initiator counts the ack, stays in WAIT with timer reset (no ISSUE state). Period becomes RESP_LAT cycles.
  - If ack=0 while a speculative req was driven: immediate protocol error -> timeout_err=1, IDLE.
- Undefined: req is only ever high in ISSUE; 6-cycle period as above.

Test Plan:
- Single transaction:
  - num_txn=1, start sampled at edge 0, responder model RESP_LAT=5.
  - req high cycle 1 only; ack cycle 6; done cycle 7; ack_count=1; busy high cycles 1-6.
- Three-transaction batch:
  - num_txn=3.
  - req pulses cycles 1, 7, 13; acks cycles 6, 12, 18; done cycle 19; ack_count=3; timeout_err=0.
- Timeout:
  - num_txn=2, responder silent, TIMEOUT_CYCLES=16.
  - req cycle 1 only; timeout_err=1 and busy=0 after 16 WAIT cycles; no done.
  - Next start clears timeout_err.
- Zero and ignored requests:
  - num_txn=0 -> done pulse cycle 1, req never high.
  - Stray ack while IDLE -> ack_count unchanged.
  - start pulsed while busy -> ignored.
- Reset mid-WAIT:
  - rst asserted asynchronously at cycle 4 of a 3-transaction batch.
  - req/busy/ack_count go to 0 without waiting for an edge; later ack ignored.
- With REQ_B2B_EN, num_txn=3:
  - req cycles 1, 6, 11; acks 6, 11, 16; done 17.
  - Responder model withholding the 2nd ack -> timeout_err=1 at cycle 12.

Source files
------------

// File: rtl/req_initiator_if.sv
// Handshake bundle between the control block, req_initiator and the responder.
// master: the initiator side; slave: the control/responder environment side.
interface req_initiator_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] num_txn;
    logic             ack;
    logic             req;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [CNT_W-1:0] ack_count;

    modport master (
        input  start, num_txn, ack,
        output req, busy, done, timeout_err, ack_count
    );

    modport slave (
        output start, num_txn, ack,
        input  req, busy, done, timeout_err, ack_count
    );
endinterface

// File: rtl/req_initiator.sv
// Requester side of the req/ack handshake: issues num_txn requests per start,
// counts acks, flags missing acks. Optional macro REQ_B2B_EN: speculative b2b req.
module req_initiator #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESP_LAT       = 5
) (
    input logic             clk,
    input logic             rst,
    req_initiator_if.master bus
);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] ack_count_q, ack_count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             spec_req;

`ifdef REQ_B2B_EN
    // Re-request in the expected ack cycle so the responder can restart at once.
    assign spec_req = (state_q == WAIT)
                   && (timer_q == TMR_W'(RESP_LAT - 1))
                   && (remaining_q > CNT_W'(1));
`else
    assign spec_req = 1'b0;
`endif

    // Next-state and counter updates for the batch sequencer.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        ack_count_d = ack_count_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    remaining_d = bus.num_txn;
                    ack_count_d = '0;
                    err_d       = 1'b0;
                    if (bus.num_txn == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.ack) begin
                    ack_count_d = ack_count_q + CNT_W'(1);
                    remaining_d = remaining_q - CNT_W'(1);
                    timer_d     = '0;
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (spec_req) begin
                        state_d = WAIT;
                    end else begin
                        state_d = ISSUE;
                    end
                end else if (spec_req) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            ack_count_q <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            ack_count_q <= ack_count_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.req         = (state_q == ISSUE) || spec_req;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
    assign bus.ack_count   = ack_count_q;
endmodule

// File: tb/tb_req_initiator.sv
// Bench for req_initiator: responder model plus arithmetic timeline model
// of each batch, checked cycle by cycle.
module tb_req_initiator;
    localparam int CNT_W = 8;
`ifdef REQ_B2B_EN
    localparam bit B2B = 1'b1;
    localparam int P   = 5;
`else
    localparam bit B2B = 1'b0;
    localparam int P   = 6;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   nreq, nack, bend, dc, ec;

    req_initiator_if #(.CNT_W(CNT_W)) bus ();

    req_initiator #(
        .CNT_W(CNT_W),
        .TIMEOUT_CYCLES(16),
        .RESP_LAT(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected batch timeline: request count, ack count, last busy cycle,
    // done cycle and error cycle (-1 when absent). d = index of withheld ack.
    task automatic plan(input int n, input int d);
        dc = -1;
        ec = -1;
        if (n == 0) begin
            nreq = 0; nack = 0; bend = 0; dc = 1;
        end else if (d >= n) begin
            nreq = n; nack = n;
            bend = B2B ? 5 * n + 1 : 6 * n;
            dc   = bend + 1;
        end else if (!B2B) begin
            nreq = d + 1; nack = d; bend = 6 * d + 17; ec = bend + 1;
        end else if (d < n - 1) begin
            nreq = d + 2; nack = d; bend = 5 * d + 6; ec = bend + 1;
        end else begin
            nreq = n; nack = d; bend = 5 * d + 17; ec = bend + 1;
        end
    endtask

    // One batch: n requests, ack #d withheld, optional start poke while busy,
    // optional asynchronous reset in cycle rc (0 = none).
    task automatic run(input int n, input int d, input bit poke, input int rc);
        int  ack_at[$];
        int  r = 0;
        int  len, stray, cnt;
        bit  rs = 1'b0;
        logic er;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_txn = CNT_W'(n);
        bus.ack     = 1'b0;
        plan(n, d);
        stray = bend;
        if (dc > stray) stray = dc;
        if (ec > stray) stray = ec;
        stray = stray + 3;
        len   = (rc > 0) ? rc + 12 : stray + 5;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (rc > 0 && c == rc + 1) rst = 1'b0;
            cnt = 0;
            for (int k = 0; k < nack; k++)
                if (6 + P * k < c) cnt++;
            er = (((c - 1) % P) == 0) && (((c - 1) / P) < nreq);
            check("req", 32'(bus.req), rs ? 32'd0 : 32'(er));
            check("busy", 32'(bus.busy), 32'(!rs && c <= bend));
            check("done", 32'(bus.done), 32'(!rs && c == dc));
            check("err", 32'(bus.timeout_err), 32'(!rs && ec > 0 && c >= ec));
            check("ack_count", 32'(bus.ack_count), rs ? 32'd0 : 32'(cnt));
            if (c == rc) begin
                #2 rst = 1'b1;
                #1;
                rs = 1'b1;
                check("rst_req", 32'(bus.req), 32'd0);
                check("rst_busy", 32'(bus.busy), 32'd0);
                check("rst_cnt", 32'(bus.ack_count), 32'd0);
            end else if (bus.req === 1'b1) begin
                if (r != d) ack_at.push_back(c + 5);
                r++;
            end
            bus.ack = (c == stray);
            foreach (ack_at[i])
                if (ack_at[i] == c) bus.ack = 1'b1;
            bus.start   = poke && (n > 0) && (c == 3);
            bus.num_txn = poke ? CNT_W'(7) : CNT_W'(n);
        end
        bus.ack   = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        int n, d;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.num_txn = '0;
        bus.ack     = 1'b0;
        #12;
        check("reset_req", 32'(bus.req), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_err", 32'(bus.timeout_err), 32'd0);
        check("reset_cnt", 32'(bus.ack_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 99, 1'b0, 0);
        run(3, 99, 1'b0, 0);
        run(2, 0, 1'b0, 0);
        run(0, 99, 1'b0, 0);
        run(3, 99, 1'b1, 0);
        run(3, 1, 1'b0, 0);
        run(3, 99, 1'b0, 4);
        run(3, 99, 1'b0, 1 + P);
        repeat (10) begin
            n = $urandom_range(0, 5);
            d = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : 99;
            run(n, d, 1'($urandom_range(0, 1)), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
